axis_sw_arb: RTL

Upstream arbiter for the AXI-Stream switch. It shares the single IO-serdes output stream among PORTS requesters: user project, axilite bridge and logic analyzer. It combines fixed-priority high-priority requests, round-robin normal requests and a configurable burst limit. It outputs a registered one-hot grant plus a TID, which drive the switch mux and the per-source tready gating.

---
 rtl/axis_sw_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axis_sw_arb.sv
// axis_sw_arb - upstream arbiter for the AXI-Stream switch.
//
// Shares the single IO-serdes output stream among PORTS requesters
// (user project, axilite bridge, logic analyzer). Combines fixed-priority
// high-priority requests, round-robin normal requests and a burst limit.
// Grant outputs are registered and drive the switch mux and tready gating.
//
// Ports:
//   axis_clk   clock
//   axis_rst   synchronous reset, active-high
//   req        per-source tvalid (normal request)
//   hi_req     per-source high-priority request (needs req[i] as well)
//   req_mask   0 disables a port entirely
//   hi_mask    0 ignores hi_req[i]
//   burst_max  max beats per normal grant, 0 = unlimited
//   beat       output handshake (tvalid & tready)
//   last       tlast of the current beat
//   grant      one-hot registered grant, zero = none
//   grant_tid  index of the granted port, 0 when no grant
//   grant_hi   current grant was issued as high priority
//   busy       grant is non-zero
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no grant; arbitrate every cycle
// ST_GRANTED | one port owns the stream until a release condition

module axis_sw_arb #(
  parameter int PORTS        = 3,
  parameter int CNT_WIDTH    = 4,
  parameter bit LAST_HI_ONLY = 1'b1
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic [PORTS-1:0]     req,
  input  logic [PORTS-1:0]     hi_req,
  input  logic [PORTS-1:0]     req_mask,
  input  logic [PORTS-1:0]     hi_mask,
  input  logic [CNT_WIDTH-1:0] burst_max,
  input  logic                 beat,
  input  logic                 last,
  output logic [PORTS-1:0]     grant,
  output logic [1:0]           grant_tid,
  output logic                 grant_hi,
  output logic                 busy
);

  typedef enum logic {ST_IDLE, ST_GRANTED} state_t;

  state_t               state;
  logic [1:0]           rr_ptr;
  logic [CNT_WIDTH-1:0] beat_cnt;

  logic [PORTS-1:0]     ereq;
  logic [PORTS-1:0]     ehi;
  logic [PORTS-1:0]     nreq;
  logic [PORTS-1:0]     nreq_x;
  logic [PORTS-1:0]     excl;
  logic                 req_cur;
  logic                 mask_cur;
  logic                 burst_hit;
  logic                 release_now;
  logic                 arb_en;
  logic                 win_valid;
  logic                 win_hi;
  logic [1:0]           win_idx;
  logic [PORTS-1:0]     win_onehot;

  assign ereq = req & req_mask;
  assign ehi  = ereq & hi_req & hi_mask;

  assign req_cur  = |(grant & req);
  assign mask_cur = |(grant & req_mask);

  // Burst limit fires on the Nth beat; hi grants may be exempt so a
  // priority packet is never split.
  assign burst_hit = beat && (burst_max != '0) &&
                     (beat_cnt == (burst_max - CNT_WIDTH'(1))) &&
                     (!grant_hi || !LAST_HI_ONLY);

  assign release_now = (state == ST_GRANTED) &&
                       ((beat && last) || burst_hit ||
                        (!req_cur && !beat) || !mask_cur);

  assign arb_en = (state == ST_IDLE) || release_now;

  // The port being released only re-wins a normal grant when nobody else
  // is asking. After a normal grant rr_ptr already points at it, but after
  // a hi grant it does not, so exclude it explicitly.
  assign excl   = release_now ? grant : '0;
  assign nreq_x = ereq & ~excl;
  assign nreq   = (nreq_x != '0) ? nreq_x : ereq;

  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_hi    = 1'b0;
    win_idx   = 2'd0;
    if (ehi != '0) begin
      // Descending scan leaves the lowest set index.
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (|(ehi & (PORTS'(1) << i))) win_idx = 2'(i);
      end
      win_valid = 1'b1;
      win_hi    = 1'b1;
    end else if (nreq != '0) begin
      // Descending distance scan leaves the nearest port after rr_ptr.
      for (int k = PORTS; k >= 1; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (|(nreq & (PORTS'(1) << idx))) win_idx = 2'(idx);
      end
      win_valid = 1'b1;
    end
  end

  assign win_onehot = PORTS'(1) << win_idx;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_tid <= 2'd0;
      grant_hi  <= 1'b0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      rr_ptr    <= 2'(PORTS - 1);
    end else begin
      if (state == ST_GRANTED && beat && beat_cnt != '1)
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);

      if (arb_en) begin
        if (win_valid) begin
          state     <= ST_GRANTED;
          grant     <= win_onehot;
          grant_tid <= win_idx;
          grant_hi  <= win_hi;
          busy      <= 1'b1;
          beat_cnt  <= '0;
          if (!win_hi) rr_ptr <= win_idx;
        end else begin
          state     <= ST_IDLE;
          grant     <= '0;
          grant_tid <= 2'd0;
          grant_hi  <= 1'b0;
          busy      <= 1'b0;
          beat_cnt  <= '0;
        end
      end
    end
  end

endmodule
